// File: rtl/bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd
//
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// It feeds the per-digit 7-segment decoders. One input bit is consumed per
// clock, so a conversion takes WIDTH cycles after the start is accepted.
//
// Parameters
//   WIDTH   width of the unsigned binary input (4..32)
//   DIGITS  number of packed BCD output digits (1..10)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     conversion request, sampled only while idle
//   bin       binary value, captured on the accepted start edge
//   busy      high while a conversion is in progress
//   valid     one-cycle pulse when bcd/blank/overflow are updated
//   bcd       packed BCD result, digit 0 (units) in bits [3:0]
//   blank     leading-zero mask, 1 = digit is an unlit leading zero
//   overflow  value did not fit in DIGITS digits (bcd is not meaningful)
// -----------------------------------------------------------------------------
module bin_to_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    // Units digit is never blanked, so an all-zero value still shows "0".
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} ^ DIGITS'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   shift_q,    shift_d;
    logic [BW-1:0]      work_q,     work_d;
    logic               ovf_acc_q,  ovf_acc_d;
    logic [CW-1:0]      cnt_q,      cnt_d;
    logic               busy_q,     busy_d;
    logic               valid_q,    valid_d;
    logic [BW-1:0]      bcd_q,      bcd_d;
    logic [DIGITS-1:0]  blank_q,    blank_d;
    logic               overflow_q, overflow_d;

    // -------------------------------------------------------------------------
    // Per-digit add-3 correction. A digit of 5..9 becomes 8..12, which fits in
    // 4 bits, so plain 4-bit arithmetic never wraps.
    // -------------------------------------------------------------------------
    logic [BW-1:0] work_adj;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign work_adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5)
                                   ? work_q[4*gi +: 4] + 4'd3
                                   : work_q[4*gi +: 4];
    end

    // Shift the corrected work register left by one, pulling in the next
    // binary bit (MSB first). The bit leaving the top digit is a carry into a
    // digit we do not have: after correction the top bit is set exactly when
    // the top digit was >= 5, i.e. when doubling would exceed 9.
    logic [BW-1:0] work_shift;
    logic          carry_out;
    logic          ovf_final;

    assign work_shift = {work_adj[BW-2:0], shift_q[WIDTH-1]};
    assign carry_out  = work_adj[BW-1];
    assign ovf_final  = ovf_acc_q | carry_out;

    // -------------------------------------------------------------------------
    // Leading-zero mask, computed from the post-shift value so it is ready on
    // the same edge as the final result. zero_from[i] means digits
    // DIGITS-1..i are all zero.
    // -------------------------------------------------------------------------
    logic [DIGITS:1]   zero_from;
    logic [DIGITS-1:0] blank_calc;

    assign zero_from[DIGITS] = 1'b1;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_units
            assign blank_calc[gi] = 1'b0;
        end else begin : g_upper
            assign zero_from[gi]  = (work_shift[4*gi +: 4] == 4'd0) && zero_from[gi+1];
            // An overflowed result is meaningless, so show every digit.
            assign blank_calc[gi] = zero_from[gi] && !ovf_final;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        ovf_acc_d  = ovf_acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    work_d    = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CW'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                work_d    = work_shift;
                shift_d   = shift_q << 1;
                ovf_acc_d = ovf_final;
                cnt_d     = cnt_q - CW'(1);

                // Counter still holds 1 on the edge doing the last shift.
                if (cnt_q == CW'(1)) begin
                    bcd_d      = work_shift;
                    overflow_d = ovf_final;
                    blank_d    = blank_calc;
                    valid_d    = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            work_q     <= '0;
            ovf_acc_q  <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= BLANK_RST;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            ovf_acc_q  <= ovf_acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign bcd      = bcd_q;
    assign blank    = blank_q;
    assign overflow = overflow_q;

endmodule

// File: doc/bin_to_bcd.md
Name: bin_to_bcd

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the 7-segment decoders. It takes a WIDTH-bit unsigned binary value and produces DIGITS packed BCD nibbles. Each nibble drives one per-digit hex decoder instance. It also produces a leading-zero blanking mask so board top levels can suppress unlit leading digits.

Parameters:
WIDTH, 16, width of the unsigned binary input (legal range 4 to 32)
DIGITS, 5, number of BCD output digits (legal range 1 to 10)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request conversion of bin; sampled only in IDLE
bin  input  WIDTH  unsigned binary value; captured on the accepted start edge
busy  output  1  high while a conversion is in progress
valid  output  1  one-cycle pulse; bcd/blank/overflow updated this cycle
bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0]
blank  output  DIGITS  1 = digit is a leading zero; bit 0 is always 0
overflow  output  1  value exceeded 10^DIGITS-1; bcd is invalid when set

Behaviour:
- Reset values (rst high at a clock edge): FSM=IDLE, busy=0, valid=0, bcd=0, overflow=0, blank={DIGITS-1 ones, 0}. Internal shift/work registers are cleared.
- FSM states: IDLE, SHIFT.
- IDLE: if start=1 at an edge, load bin into the shift register, clear the BCD work register and overflow accumulator, load the bit counter with WIDTH, go to SHIFT, and set busy=1. If start=0, remain in IDLE.
- SHIFT, one bit per cycle:
  - First, for each work digit ≥5, add 3 to that digit.
  - Then shift {work, shift_reg} left by 1, with the MSB of bin entering the work LSB.
  - If the bit shifted out of the top digit is 1, set the overflow accumulator.
  - Decrement the counter.
- On the edge that performs the final (WIDTH-th) shift:
  - Load bcd from the post-shift work value, overflow from the accumulator, and blank as computed below.
  - Assert valid=1 for exactly one cycle, deassert busy, and return to IDLE.
- Latency: start accepted at edge N; valid=1 and outputs updated following edge N+WIDTH. busy is high from after edge N through edge N+WIDTH. Throughput is one conversion per WIDTH+1 cycles.
- start while busy=1 is ignored; it is not queued.
- start in the cycle valid=1 (FSM is in IDLE) is accepted.
- bcd, blank and overflow hold their last values between conversions and change only with valid.
- blank: scan from the top digit down. blank[i]=1 iff digits DIGITS-1..i are all zero and i>0. With overflow=1, blank = all zeros.
- rst mid-conversion: abort immediately to reset values. No valid pulse is produced.
- bin is don't-care except on the accepted start edge.
- The add-3 correction uses 4-bit per-digit arithmetic. A corrected digit never exceeds 4'hC before the shift.

Test Plan:
- Reset then idle: hold rst for 2 cycles, release -> busy=0, valid=0, bcd=20'h00000, blank=5'b11110, overflow=0. No valid pulse occurs over 50 idle cycles.
- bin=16'd0, pulse start -> after exactly 16 further edges, valid=1 for 1 cycle with bcd=20'h00000, blank=5'b11110, overflow=0.
- bin=16'd1234 -> bcd=20'h01234, blank=5'b10000. bin=16'd65535 -> bcd=20'h65535, blank=5'b00000. busy is high for exactly 16 cycles each time.
- Hold start high continuously with bin=16'd9 -> start while busy is ignored; back-to-back conversions each report 20'h00009, with valid every 17 cycles.
- Assert rst at shift cycle 8 of bin=16'd4321 -> no valid pulse; outputs return to reset values. A subsequent start with 16'd42 gives bcd=20'h00042, blank=5'b11100.
- Override DIGITS=4, bin=16'd12345 -> overflow=1, blank=4'b0000. Then bin=16'd9999 -> bcd=16'h9999, overflow=0.
